// File: rtl/sdp_y_core_cfg_triosy_handshake_ctrl_if.sv
// Handshake bundle between the SDP Y-core FSM, the triosy wait datapath and the
// config register side. The controller sits on the slave modport.
interface sdp_y_core_cfg_triosy_handshake_ctrl_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    logic             core_wen;
    logic [NCH-1:0]   oswt;
    logic [NCH-1:0]   lz_vld;
    logic [NCH-1:0]   lz_rdy;
    logic [NCH-1:0]   obj_biwt;
    logic [NCH-1:0]   obj_bdwt;
    logic [NCH-1:0]   obj_bawt;
    logic             core_wten;
    logic             cnt_clr;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  core_wen, oswt, lz_rdy, cnt_clr,
        output lz_vld, obj_biwt, obj_bdwt, obj_bawt, core_wten, txn_cnt, stall_cnt
    );

    modport master (
        output core_wen, oswt, lz_rdy, cnt_clr,
        input  lz_vld, obj_biwt, obj_bdwt, obj_bawt, core_wten, txn_cnt, stall_cnt
    );
endinterface

// File: rtl/sdp_y_core_cfg_triosy_handshake_ctrl.sv
// Per-transaction triosy handshake controller: issues lz requests, tracks sticky
// per-channel completion, stalls the core until all used channels are done.
module sdp_y_core_cfg_triosy_handshake_ctrl #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rstn,
    sdp_y_core_cfg_triosy_handshake_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NCH-1:0] bcwt;
    logic [NCH-1:0] lz_vld;
    logic [NCH-1:0] biwt;
    logic [NCH-1:0] bawt;
    logic [NCH-1:0] bdwt;
    logic           core_wten;
    logic           adv;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // A completed channel stops requesting, so an accepted request is never repeated.
    always_comb begin
        lz_vld    = {NCH{bus.core_wen}} & bus.oswt & ~bcwt;
        biwt      = lz_vld & bus.lz_rdy;
        bawt      = biwt | bcwt;
        core_wten = bus.core_wen & (|(bus.oswt & ~bawt));
        adv       = bus.core_wen & ~core_wten;
        bdwt      = {NCH{adv}} & bus.oswt;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            bcwt <= '0;
        end else begin
            bcwt <= bawt & ~bdwt;
        end
    end

    // Debug counters: clear wins over a same-cycle increment.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            txn_cnt   <= '0;
            stall_cnt <= '0;
        end else if (bus.cnt_clr) begin
            txn_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (adv && (txn_cnt != CNT_MAX))
                txn_cnt <= txn_cnt + 1'b1;
            if (core_wten && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.lz_vld    = lz_vld;
    assign bus.obj_biwt  = biwt;
    assign bus.obj_bawt  = bawt;
    assign bus.obj_bdwt  = bdwt;
    assign bus.core_wten = core_wten;
    assign bus.txn_cnt   = txn_cnt;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: doc/sdp_y_core_cfg_triosy_handshake_ctrl.md
Name: sdp_y_core_cfg_triosy_handshake_ctrl

Overview:
- Per-transaction handshake controller for the SDP Y-core configuration triosy channels (cfg_alu_src, cfg_alu_op, cfg_mul_src, ...).
- Sits directly upstream of the per-channel triosy wait datapath. It generates each channel's "input write" event and "done/consumed" event, and holds the sticky completion bit.
- Drives the channel lz valid/ready handshake toward the register interface. Stalls the core FSM until every channel used in the current transaction has completed.
- Also keeps saturating transaction and stall counters for debug readout.

Parameters:
NCH, 4, number of triosy channels handled
CNT_W, 16, width of the transaction and stall counters

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rstn  input  1  asynchronous active-low reset
core_wen  input  1  core FSM requests to advance this cycle
oswt  input  NCH  channel i is used by the current core transaction
lz_vld  output  NCH  channel i lz request toward the external interface
lz_rdy  input  NCH  external side accepts the channel i lz request
obj_biwt  output  NCH  per-channel input-write event (handshake this cycle)
obj_bdwt  output  NCH  per-channel done event (transaction consumed)
obj_bawt  output  NCH  channel i complete for the current transaction
core_wten  output  1  core stall: high while any used channel is incomplete
cnt_clr  input  1  synchronous clear of both counters
txn_cnt  output  CNT_W  completed transactions, saturating
stall_cnt  output  CNT_W  cycles with core_wten high, saturating

Behaviour:
- Fixed: one clock, nvdla_core_clk. Reset nvdla_core_rstn is asynchronous and active-low.
- Reset values:
  - bcwt[NCH-1:0] = 0, txn_cnt = 0, stall_cnt = 0.
  - All outputs are combinational from these registers and the inputs. With core_wen low during reset, every output is 0.
- Per channel i, combinational:
  - biwt[i] = lz_vld[i] & lz_rdy[i]
  - bawt[i] = biwt[i] | bcwt[i]
  - lz_vld[i] = core_wen & oswt[i] & ~bcwt[i]. A request is issued only while not yet complete, so there is no re-request after acceptance.
  - core_wten = core_wen & |(oswt & ~bawt)
  - adv = core_wen & ~core_wten (transaction completes this cycle)
  - bdwt[i] = adv & oswt[i]
- Sticky state:
  - bcwt[i] <= bawt[i] & ~bdwt[i]
  - Completion is held across stall cycles and cleared on the cycle the transaction advances.
- Latency:
  - If every used channel has lz_rdy high in the first core_wen cycle, adv occurs in that same cycle (zero stall).
  - Otherwise the stall lasts until the last used channel handshakes. adv occurs in that handshake cycle.
- Channels with oswt[i]=0:
  - lz_vld[i] = 0, and the channel does not stall the core.
  - bawt[i] reflects only a leftover bcwt[i].
- lz_rdy without lz_vld is ignored.
- core_wen low while bcwt is set: state holds and no lz requests are issued. The transaction resumes when core_wen returns.
- Protocol requirement: oswt is stable while core_wten is high. The bench asserts this; the RTL does not check it.
- Counters, with priority cnt_clr > increment:
  - txn_cnt += 1 on adv, saturating at 2^CNT_W-1.
  - stall_cnt += 1 each cycle core_wten is high, saturating.
  - cnt_clr and an increment event in the same cycle: the counter becomes 0.
- Reset asserted mid-transaction: bcwt and the counters clear immediately. After release the transaction re-requests every used channel.

Test Plan:
- Reset, NCH=4, oswt=4'b1111, core_wen=1, lz_rdy=4'b1111 -> lz_vld=4'b1111, core_wten=0, bdwt=4'b1111, txn_cnt=1 next cycle, stall_cnt=0.
- Staggered readiness:
  - Stimulus: oswt=4'b0101, core_wen=1. lz_rdy[0] high in cycle 0; lz_rdy[2] low for cycles 0-2, high in cycle 3.
  - Response: core_wten=1 for cycles 0-2. lz_vld[0] drops from cycle 1 with bcwt[0]=1. adv in cycle 3. stall_cnt=3, txn_cnt=1.
- Unused channel: oswt=4'b0001, lz_rdy=4'b0000 for 2 cycles, then 4'b0001 -> lz_vld[3:1]=0 throughout; stall 2 cycles, then adv.
- core_wen drops to 0 while bcwt[0]=1 and channel 2 is pending -> lz_vld=0, bcwt[0] stays 1. On core_wen=1 with lz_rdy[2]=1 -> adv, bcwt cleared.
- Counter saturation: CNT_W=4, 20 back-to-back zero-stall transactions -> txn_cnt=15. Then cnt_clr together with adv -> txn_cnt=0.
- Reset mid-stall (bcwt=4'b0011 pending) -> bcwt=0 and counters=0 immediately. After release, lz_vld re-asserts for all channels in oswt.
